// File: rtl/sram_pkg.sv
// sram_pkg: clear-controller state type and read-during-write mode names shared by the SRAM block.
package sram_pkg;

    typedef enum logic {
        CLEARING,
        READY
    } clear_state_e;

    localparam string RDW_NEW_DATA  = "NEW_DATA";
    localparam string RDW_DONT_CARE = "DONT_CARE";

endpackage

// File: rtl/sram_clear_ctrl.sv
// sram_clear_ctrl: zero-fill sequencer; walks every address once per pass and owns the ready flag.
module sram_clear_ctrl
    import sram_pkg::*;
#(
    parameter int SIZE           = 128,
    parameter int CLEAR_ON_RESET = 1,
    parameter int ADDR_WIDTH     = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_req,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_addr,
    output logic                  ready
);

    localparam clear_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEARING : READY;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

    clear_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic                  ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (state_q == CLEARING) begin
            count_d = count_q + 1'b1;
            if (count_q == LAST_ADDR) begin
                state_d = READY;
                count_d = '0;
            end
        end else if (clear_req) begin
            state_d = CLEARING;
            count_d = '0;
        end
        // registered so ready stays low through reset even when the reset state is READY
        ready_d = (state_d == READY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_STATE;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    assign clear_we   = (state_q == CLEARING);
    assign clear_addr = count_q;
    assign ready      = ready_q;

endmodule

// File: rtl/sram_nr1w_clear.sv
// sram_nr1w_clear: N-read/1-write SRAM with registered reads, optional write bypass and a zero-fill clear pass.
module sram_nr1w_clear
    import sram_pkg::*;
#(
    parameter int    DATA_WIDTH        = 32,
    parameter int    SIZE              = 128,
    parameter int    NUM_READ_PORTS    = 2,
    parameter string READ_DURING_WRITE = RDW_NEW_DATA,
    parameter int    CLEAR_ON_RESET    = 1,
    parameter int    ADDR_WIDTH        = $clog2(SIZE)
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_READ_PORTS-1:0]            read_en,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data,
    input  logic                                 write_en,
    input  logic [ADDR_WIDTH-1:0]                write_addr,
    input  logic [DATA_WIDTH-1:0]                write_data,
    input  logic                                 clear_req,
    output logic                                 ready
);

    localparam bit BYPASS = (READ_DURING_WRITE == RDW_NEW_DATA);

    logic [DATA_WIDTH-1:0]                mem [SIZE];
    logic                                 clear_we;
    logic [ADDR_WIDTH-1:0]                clear_addr;
    logic                                 user_we;
    logic [ADDR_WIDTH-1:0]                raddr;
    logic                                 hit;
    logic [DATA_WIDTH-1:0]                rword;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data_q, read_data_d;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < (ADDR_WIDTH + 1)'(SIZE);
    endfunction

    sram_clear_ctrl #(
        .SIZE          (SIZE),
        .CLEAR_ON_RESET(CLEAR_ON_RESET),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_ctrl (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_req (clear_req),
        .clear_we  (clear_we),
        .clear_addr(clear_addr),
        .ready     (ready)
    );

    assign user_we = ready && write_en && in_range(write_addr);

    always_ff @(posedge clk) begin
        if (clear_we || user_we)
            mem[clear_we ? clear_addr : write_addr] <= clear_we ? '0 : write_data;
    end

    always_comb begin
        read_data_d = read_data_q;
        raddr       = '0;
        hit         = 1'b0;
        rword       = '0;
        for (int i = 0; i < NUM_READ_PORTS; i++) begin
            raddr = read_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            // BYPASS is a constant, so DONT_CARE builds no compare at all
            hit   = BYPASS && user_we && (write_addr == raddr);
            rword = !in_range(raddr) ? '0 : hit ? write_data : mem[raddr];
            read_data_d[i*DATA_WIDTH +: DATA_WIDTH] = !ready ? '0
                : read_en[i] ? rword : read_data_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            read_data_q <= '0;
        else
            read_data_q <= read_data_d;
    end

    assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_nr1w_clear.sv
// tb_sram_nr1w_clear: directed checks of the SRAM against hand-computed values for NEW_DATA, DONT_CARE and SIZE=52 instances.
module tb_sram_nr1w_clear;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  read_en;
    logic [13:0] read_addr;
    logic [63:0] read_data, read_data_dc;
    logic        write_en;
    logic [6:0]  write_addr;
    logic [31:0] write_data;
    logic        clear_req;
    logic        ready, ready_dc;

    logic [1:0]  s_re;
    logic [11:0] s_ra;
    logic [63:0] s_rd;
    logic        s_we;
    logic [5:0]  s_wa;
    logic [31:0] s_wd;
    logic        s_clr;
    logic        s_ready;

    int tests = 0;
    int fails = 0;
    int n1, n2;

    always #5 clk = ~clk;

    sram_nr1w_clear #(
        .DATA_WIDTH(32), .SIZE(128), .NUM_READ_PORTS(2),
        .READ_DURING_WRITE("NEW_DATA"), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .read_en(read_en), .read_addr(read_addr),
        .read_data(read_data), .write_en(write_en), .write_addr(write_addr),
        .write_data(write_data), .clear_req(clear_req), .ready(ready)
    );

    sram_nr1w_clear #(
        .DATA_WIDTH(32), .SIZE(128), .NUM_READ_PORTS(2),
        .READ_DURING_WRITE("DONT_CARE"), .CLEAR_ON_RESET(1)
    ) dut_dc (
        .clk(clk), .reset_n(reset_n), .read_en(read_en), .read_addr(read_addr),
        .read_data(read_data_dc), .write_en(write_en), .write_addr(write_addr),
        .write_data(write_data), .clear_req(clear_req), .ready(ready_dc)
    );

    sram_nr1w_clear #(
        .DATA_WIDTH(32), .SIZE(52), .NUM_READ_PORTS(2),
        .READ_DURING_WRITE("NEW_DATA"), .CLEAR_ON_RESET(1)
    ) dut52 (
        .clk(clk), .reset_n(reset_n), .read_en(s_re), .read_addr(s_ra),
        .read_data(s_rd), .write_en(s_we), .write_addr(s_wa),
        .write_data(s_wd), .clear_req(s_clr), .ready(s_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        read_en    = 2'b00;
        read_addr  = '0;
        write_en   = 1'b0;
        write_addr = '0;
        write_data = '0;
    endtask

    task automatic rd(input logic [1:0] en, input logic [6:0] a0, input logic [6:0] a1);
        read_en   = en;
        read_addr = {a1, a0};
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        write_en   = 1'b1;
        write_addr = a;
        write_data = d;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_req = 1'b0;
        idle();
        s_re = '0; s_ra = '0; s_we = 1'b0; s_wa = '0; s_wd = '0; s_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_rd0", read_data[31:0], 32'd0);
        chk("rst_rd1", read_data[63:32], 32'd0);
        chk("rst_ready52", {31'd0, s_ready}, 32'd0);

        reset_n = 1'b1;
        n1 = 0; n2 = 0;
        for (int i = 0; i < 200; i++) begin
            if (!ready) n1++;
            if (!s_ready) n2++;
            @(negedge clk);
        end
        chk("pass_len128", n1, 32'd128);
        chk("pass_len52", n2, 32'd52);
        chk("ready_after_pass", {31'd0, ready}, 32'd1);

        rd(2'b11, 7'd0, 7'd64);
        @(negedge clk);
        chk("init_rd_a0", read_data[31:0], 32'd0);
        chk("init_rd_a64", read_data[63:32], 32'd0);
        rd(2'b01, 7'd127, 7'd0);
        @(negedge clk);
        chk("init_rd_a127", read_data[31:0], 32'd0);
        idle();

        wr(7'd5, 32'hDEADBEEF);
        @(negedge clk);
        idle();
        rd(2'b01, 7'd5, 7'd0);
        @(negedge clk);
        idle();
        chk("wr_rd_a5", read_data[31:0], 32'hDEADBEEF);
        chk("wr_rd_a5_dc", read_data_dc[31:0], 32'hDEADBEEF);
        read_addr = {7'd0, 7'd7};
        @(negedge clk);
        chk("hold_a5", read_data[31:0], 32'hDEADBEEF);

        wr(7'd9, 32'h1234);
        rd(2'b11, 7'd9, 7'd9);
        @(negedge clk);
        idle();
        chk("bypass_p0", read_data[31:0], 32'h1234);
        chk("bypass_p1", read_data[63:32], 32'h1234);
        chk("dc_old_p0", read_data_dc[31:0], 32'd0);
        chk("dc_old_p1", read_data_dc[63:32], 32'd0);
        rd(2'b10, 7'd0, 7'd9);
        @(negedge clk);
        idle();
        chk("dc_after_commit", read_data_dc[63:32], 32'h1234);

        s_we = 1'b1; s_wa = 6'd60; s_wd = 32'h77;
        s_re = 2'b11; s_ra = {6'd60, 6'd60};
        @(negedge clk);
        s_we = 1'b0; s_re = 2'b00;
        chk("oor_same_edge_p0", s_rd[31:0], 32'd0);
        chk("oor_same_edge_p1", s_rd[63:32], 32'd0);
        s_we = 1'b1; s_wa = 6'd51; s_wd = 32'h51;
        @(negedge clk);
        s_we = 1'b0;
        s_re = 2'b11; s_ra = {6'd8, 6'd51};
        @(negedge clk);
        chk("last_addr_51", s_rd[31:0], 32'h51);
        chk("alias_addr_8", s_rd[63:32], 32'd0);
        s_re = 2'b01; s_ra = {6'd0, 6'd60};
        @(negedge clk);
        s_re = 2'b00;
        chk("oor_read_60", s_rd[31:0], 32'd0);

        wr(7'd3, 32'hA5);
        @(negedge clk);
        idle();
        clear_req = 1'b1;
        rd(2'b01, 7'd3, 7'd0);
        @(negedge clk);
        clear_req = 1'b0;
        idle();
        chk("clr_cycle_read", read_data[31:0], 32'hA5);
        chk("clr_ready_low", {31'd0, ready}, 32'd0);
        n1 = 0;
        for (int i = 0; i < 300; i++) begin
            clear_req = (i == 10);
            if (!ready) n1++;
            if (i == 5) chk("clr_rd_zero", read_data[31:0], 32'd0);
            @(negedge clk);
        end
        clear_req = 1'b0;
        chk("clr_single_pass", n1, 32'd128);
        chk("clr_ready_dc", {31'd0, ready_dc}, 32'd1);
        rd(2'b11, 7'd3, 7'd5);
        @(negedge clk);
        idle();
        chk("clr_a3_zero", read_data[31:0], 32'd0);
        chk("clr_a5_zero", read_data[63:32], 32'd0);

        wr(7'd2, 32'h55);
        @(negedge clk);
        idle();
        rd(2'b01, 7'd2, 7'd0);
        @(negedge clk);
        idle();
        chk("pre_rst_rd", read_data[31:0], 32'h55);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_rd0", read_data[31:0], 32'd0);
        chk("async_rst_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n1 = 0;
        for (int i = 0; i < 200; i++) begin
            if (!ready) n1++;
            @(negedge clk);
        end
        chk("rst_pass_len", n1, 32'd128);

        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (40) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midpass_rst_ready", {31'd0, ready}, 32'd0);
        chk("midpass_rst_rd1", read_data[63:32], 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        n1 = 0;
        for (int i = 0; i < 200; i++) begin
            if (!ready) n1++;
            @(negedge clk);
        end
        chk("midpass_restart_len", n1, 32'd128);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
